bsg_nasti_mem_responder: RTL



---
 rtl/bsg_nasti_mem_responder_if.sv | 83 ++++++++
 rtl/bsg_nasti_mem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_nasti_mem_responder_if.sv
// NASTI (AXI4) channel payload structs and the five-channel bus interface
// that bsg_nasti_mem_responder terminates.

package bsg_nasti_pkg;

    localparam int unsigned id_width_lp   = 6;
    localparam int unsigned addr_width_lp = 32;
    localparam int unsigned len_width_lp  = 8;
    localparam int unsigned data_width_lp = 64;
    localparam int unsigned strb_width_lp = data_width_lp / 8;

    // AR / AW payload
    typedef struct packed {
        logic [id_width_lp-1:0]   id;
        logic [addr_width_lp-1:0] addr;
        logic [len_width_lp-1:0]  len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } bsg_nasti_a_pkt;

    // W payload
    typedef struct packed {
        logic [data_width_lp-1:0] data;
        logic [strb_width_lp-1:0] strb;
        logic                     last;
    } bsg_nasti_w_pkt;

    // B payload
    typedef struct packed {
        logic [id_width_lp-1:0] id;
        logic [1:0]             resp;
    } bsg_nasti_b_pkt;

    // R payload
    typedef struct packed {
        logic [id_width_lp-1:0]   id;
        logic [data_width_lp-1:0] data;
        logic [1:0]               resp;
        logic                     last;
    } bsg_nasti_r_pkt;

endpackage

interface bsg_nasti_mem_responder_if;
    import bsg_nasti_pkg::*;

    logic           nasti_aw_valid;
    bsg_nasti_a_pkt nasti_aw_data;
    logic           nasti_aw_ready;

    logic           nasti_w_valid;
    bsg_nasti_w_pkt nasti_w_data;
    logic           nasti_w_ready;

    logic           nasti_b_valid;
    bsg_nasti_b_pkt nasti_b_data;
    logic           nasti_b_ready;

    logic           nasti_ar_valid;
    bsg_nasti_a_pkt nasti_ar_data;
    logic           nasti_ar_ready;

    logic           nasti_r_valid;
    bsg_nasti_r_pkt nasti_r_data;
    logic           nasti_r_ready;

    modport master (
        output nasti_aw_valid, nasti_aw_data, input  nasti_aw_ready,
        output nasti_w_valid,  nasti_w_data,  input  nasti_w_ready,
        input  nasti_b_valid,  nasti_b_data,  output nasti_b_ready,
        output nasti_ar_valid, nasti_ar_data, input  nasti_ar_ready,
        input  nasti_r_valid,  nasti_r_data,  output nasti_r_ready
    );

    modport slave (
        input  nasti_aw_valid, nasti_aw_data, output nasti_aw_ready,
        input  nasti_w_valid,  nasti_w_data,  output nasti_w_ready,
        output nasti_b_valid,  nasti_b_data,  input  nasti_b_ready,
        input  nasti_ar_valid, nasti_ar_data, output nasti_ar_ready,
        output nasti_r_valid,  nasti_r_data,  input  nasti_r_ready
    );

endinterface

// File: rtl/bsg_nasti_mem_responder.sv
// NASTI (AXI4) slave backed by a byte-addressable on-chip memory, one
// transaction at a time, round-robin between reads and writes.
// Optional handshake tracing: define BSG_NASTI_MEM_RESPONDER_TRACE_EN.

module bsg_nasti_mem_responder
    import bsg_nasti_pkg::*;
#(
    parameter int unsigned els_p = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bsg_nasti_mem_responder_if.slave nasti
);

    localparam int unsigned data_w = data_width_lp;
    localparam int unsigned bytes  = data_w / 8;
    localparam int unsigned lg_b   = $clog2(bytes);
    localparam int unsigned lg_els = $clog2(els_p);
    localparam int unsigned hi_lsb = lg_b + lg_els;

    typedef enum logic [1:0] {IDLE, RD, WD, WB} state_e;

    state_e                   state_r, state_n;
    logic                     rd_pri_r;
    logic [id_width_lp-1:0]   id_r;
    logic [len_width_lp-1:0]  len_r;
    logic [len_width_lp-1:0]  beat_r;
    logic [1:0]               burst_r;
    logic [lg_els-1:0]        idx_r;
    logic                     oor_r;
    logic                     w_err_r;
    logic [1:0]               b_resp_r;

    logic [data_w-1:0]        mem [els_p];

    logic                     ar_rdy, aw_rdy;
    logic                     ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic                     beat_is_last;
    logic                     w_last_err;
    logic [lg_els-1:0]        idx_next;
    bsg_nasti_a_pkt           a_sel;
    logic                     unused_bits;

    assign a_sel        = ar_hs ? nasti.nasti_ar_data : nasti.nasti_aw_data;
    assign beat_is_last = (beat_r == len_r);
    assign w_last_err   = (nasti.nasti_w_data.last != beat_is_last);
    assign idx_next     = (burst_r == 2'b00) ? idx_r : idx_r + lg_els'(1);
    assign unused_bits  = ^{a_sel.size, a_sel.addr[lg_b-1:0]};

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n;
    end

    // Next state, channel handshakes and bus outputs
    always_comb begin
        state_n              = state_r;
        ar_rdy               = 1'b0;
        aw_rdy               = 1'b0;
        ar_hs                = 1'b0;
        aw_hs                = 1'b0;
        r_hs                 = 1'b0;
        w_hs                 = 1'b0;
        b_hs                 = 1'b0;
        nasti.nasti_ar_ready = 1'b0;
        nasti.nasti_aw_ready = 1'b0;
        nasti.nasti_w_ready  = 1'b0;
        nasti.nasti_r_valid  = 1'b0;
        nasti.nasti_r_data   = '0;
        nasti.nasti_b_valid  = 1'b0;
        nasti.nasti_b_data   = '0;

        unique case (state_r)
            IDLE: begin
                ar_rdy               = ~nasti.nasti_aw_valid | rd_pri_r;
                aw_rdy               = ~nasti.nasti_ar_valid | ~rd_pri_r;
                nasti.nasti_ar_ready = ar_rdy;
                nasti.nasti_aw_ready = aw_rdy;
                ar_hs                = nasti.nasti_ar_valid & ar_rdy;
                aw_hs                = nasti.nasti_aw_valid & aw_rdy & ~ar_hs;
                if (ar_hs)      state_n = RD;
                else if (aw_hs) state_n = WD;
            end
            RD: begin
                nasti.nasti_r_valid     = 1'b1;
                nasti.nasti_r_data.id   = id_r;
                nasti.nasti_r_data.data = oor_r ? '0 : mem[idx_r];
                nasti.nasti_r_data.resp = oor_r ? 2'b11 : 2'b00;
                nasti.nasti_r_data.last = beat_is_last;
                r_hs                    = nasti.nasti_r_ready;
                if (r_hs && beat_is_last) state_n = IDLE;
            end
            WD: begin
                nasti.nasti_w_ready = 1'b1;
                w_hs                = nasti.nasti_w_valid;
                if (w_hs && beat_is_last) state_n = WB;
            end
            WB: begin
                nasti.nasti_b_valid     = 1'b1;
                nasti.nasti_b_data.id   = id_r;
                nasti.nasti_b_data.resp = b_resp_r;
                b_hs                    = nasti.nasti_b_ready;
                if (b_hs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Transaction context: latched on address handshake, stepped per beat
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_pri_r <= 1'b1;
            id_r     <= '0;
            len_r    <= '0;
            beat_r   <= '0;
            burst_r  <= '0;
            idx_r    <= '0;
            oor_r    <= 1'b0;
            w_err_r  <= 1'b0;
            b_resp_r <= '0;
        end else begin
            if (ar_hs || aw_hs) begin
                rd_pri_r <= ~rd_pri_r;
                id_r     <= a_sel.id;
                len_r    <= a_sel.len;
                burst_r  <= a_sel.burst;
                idx_r    <= a_sel.addr[lg_b +: lg_els];
                oor_r    <= |a_sel.addr[addr_width_lp-1:hi_lsb];
                beat_r   <= '0;
                w_err_r  <= 1'b0;
            end
            if (r_hs || w_hs) begin
                beat_r <= beat_r + len_width_lp'(1);
                idx_r  <= idx_next;
            end
            if (w_hs) begin
                w_err_r <= w_err_r | w_last_err;
                if (beat_is_last) begin
                    b_resp_r <= (w_err_r | w_last_err) ? 2'b10 :
                                oor_r                  ? 2'b11 : 2'b00;
                end
            end
        end
    end

    // Byte-strobed memory write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_hs && !reset_i && !oor_r) begin
            for (int i = 0; i < bytes; i++) begin
                if (nasti.nasti_w_data.strb[i]) begin
                    mem[idx_r][8*i +: 8] <= nasti.nasti_w_data.data[8*i +: 8];
                end
            end
        end
    end

`ifdef BSG_NASTI_MEM_RESPONDER_TRACE_EN
    // Per-handshake field trace
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (ar_hs) begin
                $display("RESP_AR = id:%b",    nasti.nasti_ar_data.id);
                $display("RESP_AR = addr:%b",  nasti.nasti_ar_data.addr);
                $display("RESP_AR = len:%b",   nasti.nasti_ar_data.len);
                $display("RESP_AR = size:%b",  nasti.nasti_ar_data.size);
                $display("RESP_AR = burst:%b", nasti.nasti_ar_data.burst);
            end
            if (aw_hs) begin
                $display("RESP_AW = id:%b",    nasti.nasti_aw_data.id);
                $display("RESP_AW = addr:%b",  nasti.nasti_aw_data.addr);
                $display("RESP_AW = len:%b",   nasti.nasti_aw_data.len);
                $display("RESP_AW = size:%b",  nasti.nasti_aw_data.size);
                $display("RESP_AW = burst:%b", nasti.nasti_aw_data.burst);
            end
            if (w_hs) begin
                $display("RESP_W = data:%b", nasti.nasti_w_data.data);
                $display("RESP_W = strb:%b", nasti.nasti_w_data.strb);
                $display("RESP_W = last:%b", nasti.nasti_w_data.last);
            end
            if (r_hs) begin
                $display("RESP_R = id:%b",   nasti.nasti_r_data.id);
                $display("RESP_R = data:%b", nasti.nasti_r_data.data);
                $display("RESP_R = resp:%b", nasti.nasti_r_data.resp);
                $display("RESP_R = last:%b", nasti.nasti_r_data.last);
            end
            if (b_hs) begin
                $display("RESP_B = id:%b",   nasti.nasti_b_data.id);
                $display("RESP_B = resp:%b", nasti.nasti_b_data.resp);
            end
        end
    end
`endif

endmodule
